// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types, defaults and helpers for the memory arbiter
package mem_arb_pkg;

    localparam int ADDR_W_DFLT = 15;
    localparam int DATA_W_DFLT = 16;
    // Requester indices fit in two bits: at most four requesters share the memory.
    localparam int IDX_W       = 2;

    typedef enum logic {
        ARB_FREE,
        ARB_LOCKED
    } arb_state_t;

    function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] ptr, input int nreq);
        if (int'(ptr) + 1 >= nreq) begin
            return '0;
        end
        return ptr + IDX_W'(1);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester, response and memory-side signals of the arbiter
interface mem_arbiter_if #(
    parameter int NREQ   = 2,
    parameter int ADDR_W = mem_arb_pkg::ADDR_W_DFLT,
    parameter int DATA_W = mem_arb_pkg::DATA_W_DFLT
);
    logic [NREQ-1:0]             req_valid;
    logic [NREQ-1:0]             req_we;
    logic [NREQ-1:0]             req_lock;
    logic [NREQ-1:0][ADDR_W-1:0] req_addr;
    logic [NREQ-1:0][DATA_W-1:0] req_wdata;
    logic [NREQ-1:0]             req_ready;
    logic [NREQ-1:0]             rsp_valid;
    logic [DATA_W-1:0]           rsp_rdata;
    logic                        mem_we;
    logic [ADDR_W-1:0]           mem_addr;
    logic [DATA_W-1:0]           mem_wdata;
    logic [DATA_W-1:0]           mem_rdata;

    modport master (
        output req_valid, req_we, req_lock, req_addr, req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  req_valid, req_we, req_lock, req_addr, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational first-valid search starting at a rotating pointer
module rr_picker
    import mem_arb_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0]  valid,
    input  logic [IDX_W-1:0] start,
    output logic [NREQ-1:0]  grant,
    output logic [IDX_W-1:0] idx
);

    logic found;

    // First pass covers start..NREQ-1, second pass wraps around to 0..start-1.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && valid[k] && (k >= int'(start))) begin
                found    = 1'b1;
                grant[k] = 1'b1;
                idx      = IDX_W'(k);
            end
        end
        for (int k = 0; k < NREQ; k++) begin
            if (!found && valid[k]) begin
                found    = 1'b1;
                grant[k] = 1'b1;
                idx      = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin single-port memory arbiter with bounded lock
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NREQ     = 2,
    parameter int ADDR_W   = ADDR_W_DFLT,
    parameter int DATA_W   = DATA_W_DFLT,
    parameter int LOCK_MAX = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus
);

    localparam int CNT_W   = $clog2(LOCK_MAX + 1);
    localparam bit LOCK_EN = (LOCK_MAX > 1);

    arb_state_t        state, state_n;
    logic [IDX_W-1:0]  owner, owner_n;
    logic [IDX_W-1:0]  rr_ptr, rr_ptr_n;
    logic [CNT_W-1:0]  lock_cnt, lock_cnt_n;
    logic [NREQ-1:0]   rsp_valid_q;

    logic [NREQ-1:0]   owner_mask;
    logic [NREQ-1:0]   pick_valid;
    logic [NREQ-1:0]   pick_grant;
    logic [NREQ-1:0]   gnt_vec;
    logic [IDX_W-1:0]  gnt_idx;
    logic              accept;
    logic              gnt_lock;
    logic              lock_last;
    logic [ADDR_W-1:0] addr_mux;
    logic [DATA_W-1:0] wdata_mux;

    always_comb begin
        for (int k = 0; k < NREQ; k++) begin
            owner_mask[k] = (owner == IDX_W'(k));
        end
    end

    assign pick_valid = (state == ARB_LOCKED) ? (bus.req_valid & owner_mask) : bus.req_valid;

    rr_picker #(.NREQ(NREQ)) u_picker (
        .valid (pick_valid),
        .start ((state == ARB_LOCKED) ? owner : rr_ptr),
        .grant (pick_grant),
        .idx   (gnt_idx)
    );

    assign gnt_vec   = rst_n ? pick_grant : '0;
    assign accept    = |gnt_vec;
    assign gnt_lock  = |(gnt_vec & bus.req_lock);
    // The cycle in which the lock has been held for LOCK_MAX cycles, entry cycle included.
    assign lock_last = (state == ARB_LOCKED) && (lock_cnt == CNT_W'(LOCK_MAX - 1));

    always_comb begin
        addr_mux  = '0;
        wdata_mux = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (gnt_vec[k]) begin
                addr_mux  = bus.req_addr[k];
                wdata_mux = bus.req_wdata[k];
            end
        end
    end

    assign bus.req_ready = gnt_vec;
    assign bus.mem_we    = |(gnt_vec & bus.req_we);
    assign bus.mem_addr  = addr_mux;
    assign bus.mem_wdata = wdata_mux;
    // A response due in a reset cycle is dropped.
    assign bus.rsp_valid = rst_n ? rsp_valid_q : '0;
    assign bus.rsp_rdata = (|bus.rsp_valid) ? bus.mem_rdata : '0;

    always_comb begin
        state_n    = state;
        owner_n    = owner;
        rr_ptr_n   = rr_ptr;
        lock_cnt_n = lock_cnt;
        case (state)
            ARB_FREE: begin
                if (accept) begin
                    rr_ptr_n = rr_next(gnt_idx, NREQ);
                    if (gnt_lock && LOCK_EN) begin
                        state_n    = ARB_LOCKED;
                        owner_n    = gnt_idx;
                        lock_cnt_n = CNT_W'(1);
                    end
                end
            end
            ARB_LOCKED: begin
                lock_cnt_n = lock_cnt + CNT_W'(1);
                if (lock_last || (accept && !gnt_lock)) begin
                    state_n    = ARB_FREE;
                    rr_ptr_n   = rr_next(owner, NREQ);
                    lock_cnt_n = '0;
                end
            end
            default: state_n = ARB_FREE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ARB_FREE;
            owner       <= '0;
            rr_ptr      <= '0;
            lock_cnt    <= '0;
            rsp_valid_q <= '0;
        end else begin
            state       <= state_n;
            owner       <= owner_n;
            rr_ptr      <= rr_ptr_n;
            lock_cnt    <= lock_cnt_n;
            rsp_valid_q <= gnt_vec & ~bus.req_we;
        end
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single-port 16-bit word memory (`Memory`) between NREQ requesters, e.g. CPU instruction/data traffic and a loader/debug port. It arbitrates round-robin, with an optional bounded lock for read-modify-write sequences. It drives the memory's write-enable, word address and write data, and routes the synchronous read data back to the requester that issued the read. It sits between the requester ports and `Memory`, in place of the direct CPU-to-memory connection.

## Interface
- NREQ, 2, number of requesters (2..4)
- ADDR_W, 15, word address width (byte address bits [15:1])
- DATA_W, 16, data width
- LOCK_MAX, 8, maximum consecutive cycles a lock may hold the grant (≥1)
- clk  in  1  single clock, all state updates on posedge
- rst_n  in  1  synchronous, active-low reset, sampled on posedge clk
- req_valid  in  NREQ  request present, per requester
- req_we  in  NREQ  1 = write, 0 = read
- req_lock  in  NREQ  keep grant after this beat
- req_addr  in  NREQ×ADDR_W  word address
- req_wdata  in  NREQ×DATA_W  write data
- req_ready  out  NREQ  beat accepted this cycle (valid & ready)
- rsp_valid  out  NREQ  read data valid this cycle
- rsp_rdata  out  DATA_W  read data, shared bus, qualified by rsp_valid
- mem_we  out  1  to Memory write enable
- mem_addr  out  ADDR_W  to Memory address
- mem_wdata  out  DATA_W  to Memory data in
- mem_rdata  in  DATA_W  from Memory data out, valid one cycle after the address edge

## Operation
- At most one beat is accepted per cycle. A beat is accepted when req_valid[i] & req_ready[i]. Requesters hold all req_* stable until accepted.
- FREE state: grant goes to the first valid requester, searching from rr_ptr upward modulo NREQ. After an accepted beat from i, rr_ptr ← (i+1) mod NREQ. With no valid requester, rr_ptr is unchanged.
- Granted requester: mem_we = req_we[i], mem_addr = req_addr[i], mem_wdata = req_wdata[i]. With no grant: mem_we = 0, mem_addr = 0, mem_wdata = 0.
- Read accepted from i: rsp_valid[i] = 1 exactly one cycle later, with rsp_rdata = mem_rdata. Writes produce no response. Reads are pipelined, so back-to-back reads give back-to-back responses.
- LOCKED state is entered when the accepted beat has req_lock = 1. Owner ← i, lock_cnt ← 1.
  - While LOCKED, only the owner can be granted; all other req_ready are 0.
  - lock_cnt increments every LOCKED cycle, idle cycles included.
  - Exit to FREE when the owner's accepted beat has req_lock = 0, or when lock_cnt reaches LOCK_MAX. On that forced release the beat in the LOCK_MAX-th cycle is still granted if valid, and the lock is dropped after it.
  - rr_ptr ← owner+1 on exit.
- Lock request during a forced-release beat is ignored: the next state is FREE.
- Reset: rr_ptr = 0, state FREE, owner = 0, lock_cnt = 0, rsp_valid = 0, rsp_rdata = 0. req_ready = 0 and mem_we = 0 while rst_n = 0. A read accepted in the cycle before reset asserts produces no response.

## Timing
- req_ready and mem_* are combinational from req_* and registered state. Request-to-accept latency is 0 cycles when granted.
- Write is committed at the accepting posedge. Read data appears one cycle after acceptance.
- Registered: rsp_valid (one-hot), response tag, rr_ptr, state, owner, lock_cnt.
- Write then read to the same address in consecutive cycles returns the new data.
- Worst-case wait for an unlocked requester: (NREQ−1)×LOCK_MAX cycles.

## Structure
- Package mem_arb_pkg holds:
  - ADDR_W/DATA_W defaults
  - state enum {ARB_FREE, ARB_LOCKED}
  - function rr_next(ptr, nreq)
- Sub-module rr_picker(NREQ): inputs valid vector and start pointer; outputs one-hot grant and index. It is purely combinational.
- The top holds the FSM, lock counter and response tag pipeline register.

## Test plan
- Reset: hold rst_n = 0 two cycles with all req_valid = 1 → req_ready = 0, mem_we = 0, rsp_valid = 0. After release, requester 0 is granted first.
- Contention: req 0 and req 1 both issue continuous reads of 0x0002 and 0x0003 (memory preloaded 0x81ff, 0x1234) → grants alternate 0,1,0,1. rsp_valid alternates with rdata 0x81ff and 0x1234, each one cycle after its accept.
- Write/read hazard: req 1 writes 0xBEEF to 0x0010, next cycle reads 0x0010 → rsp_valid[1] with 0xBEEF. No response is generated for the write.
- Lock: req 0 sends read with lock = 1, then write with lock = 0, while req 1 is valid throughout → req 1 is not ready until after req 0's write. req 1 is granted the following cycle.
- Forced release: LOCK_MAX = 4, req 0 keeps lock = 1 continuously → req 0 is granted 4 cycles, then req 1 is granted in cycle 5.
- Reset mid-read: read accepted, rst_n = 0 in the next cycle → rsp_valid stays 0. State returns to FREE with rr_ptr = 0.
